// File: rtl/lcd_text_arbiter_if.sv
// rtl/lcd_text_arbiter_if.sv - LCD read port, two write requesters and bulk command bus
interface lcd_text_arbiter_if;
  logic [4:0] lcd_addr;
  logic [7:0] lcd_data;

  logic       a_req;
  logic [4:0] a_addr;
  logic [7:0] a_data;
  logic       a_gnt;

  logic       b_req;
  logic [4:0] b_addr;
  logic [7:0] b_data;
  logic       b_gnt;

  logic       cmd_clear;
  logic       cmd_scroll;
  logic       busy;

  modport master (
    output lcd_addr,
    input  lcd_data,
    output a_req, a_addr, a_data,
    input  a_gnt,
    output b_req, b_addr, b_data,
    input  b_gnt,
    output cmd_clear, cmd_scroll,
    input  busy
  );

  modport slave (
    input  lcd_addr,
    output lcd_data,
    input  a_req, a_addr, a_data,
    output a_gnt,
    input  b_req, b_addr, b_data,
    output b_gnt,
    input  cmd_clear, cmd_scroll,
    output busy
  );
endinterface

// File: rtl/lcd_text_arbiter.sv
// rtl/lcd_text_arbiter.sv - 2x16 LCD text buffer with round-robin write arbitration
// and clear / scroll-up bulk sequencing.
module lcd_text_arbiter #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         ROW_LEN   = 16
) (
  input  logic               clk,
  input  logic               rst,
  lcd_text_arbiter_if.slave  bus
);

  localparam int         DEPTH     = 2 * ROW_LEN;
  localparam logic [4:0] LAST_IDX  = 5'(DEPTH - 1);
  localparam logic [4:0] ROW_END   = 5'(ROW_LEN - 1);
  localparam logic [4:0] ROW1_BASE = 5'(ROW_LEN);

  typedef enum logic [1:0] {
    CLEAR       = 2'd0,
    IDLE        = 2'd1,
    SCROLL_COPY = 2'd2,
    SCROLL_FILL = 2'd3
  } state_t;

  logic [7:0] mem [DEPTH];

  state_t     state;
  logic [4:0] idx;
  logic       last_b;

  logic       arb_open;
  logic       a_gnt;
  logic       b_gnt;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;

  // Commands take the cycle away from the requesters, so grants only open
  // on an IDLE cycle with no command pulse.
  always_comb begin
    arb_open = (state == IDLE) && !bus.cmd_clear && !bus.cmd_scroll;
    a_gnt    = arb_open && bus.a_req && (!bus.b_req || last_b);
    b_gnt    = arb_open && bus.b_req && (!bus.a_req || !last_b);
  end

  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = FILL_CHAR;
    case (state)
      CLEAR:       we = 1'b1;
      SCROLL_COPY: begin
        we    = 1'b1;
        wdata = mem[idx + ROW1_BASE];
      end
      SCROLL_FILL: we = 1'b1;
      IDLE: begin
        if (a_gnt) begin
          we    = 1'b1;
          waddr = bus.a_addr;
          wdata = bus.a_data;
        end else if (b_gnt) begin
          we    = 1'b1;
          waddr = bus.b_addr;
          wdata = bus.b_data;
        end
      end
      default: we = 1'b0;
    endcase
  end

  // The array has no reset; gating on rst drops any write caught by reset.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      idx    <= 5'd0;
      last_b <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == LAST_IDX) begin
            idx   <= 5'd0;
            state <= IDLE;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        SCROLL_COPY: begin
          if (idx == ROW_END) begin
            idx   <= ROW1_BASE;
            state <= SCROLL_FILL;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        SCROLL_FILL: begin
          if (idx == LAST_IDX) begin
            idx   <= 5'd0;
            state <= IDLE;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        IDLE: begin
          if (bus.cmd_clear) begin
            idx   <= 5'd0;
            state <= CLEAR;
          end else if (bus.cmd_scroll) begin
            idx   <= 5'd0;
            state <= SCROLL_COPY;
          end else if (a_gnt) begin
            last_b <= 1'b0;
          end else if (b_gnt) begin
            last_b <= 1'b1;
          end
        end
        default: begin
          idx   <= 5'd0;
          state <= CLEAR;
        end
      endcase
    end
  end

  assign bus.lcd_data = mem[bus.lcd_addr];
  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// tb/tb_lcd_text_arbiter.sv - table-driven and directed checks for lcd_text_arbiter
module tb_lcd_text_arbiter;
  logic clk;
  logic rst;

  lcd_text_arbiter_if bus ();

  lcd_text_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a_req;
    logic       b_req;
    logic [4:0] a_addr;
    logic [4:0] b_addr;
    logic [7:0] a_data;
    logic [7:0] b_data;
    logic       clr;
    logic       scr;
    logic       ea;
    logic       eb;
    logic       ebusy;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] model [32];
  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         n_busy;
  int         n_gnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.lcd_addr = 5'(i);
      #1;
      chk($sformatf("%s buf[%0d]", tag, i), {24'd0, bus.lcd_data}, {24'd0, model[i]});
    end
  endtask

  task automatic fill_model(input logic [7:0] v);
    for (int i = 0; i < 32; i++) model[i] = v;
  endtask

  // Counts busy cycles at negedges; optionally pulses cmd_scroll at one busy cycle.
  task automatic wait_idle(input int inject_at, output int n, output int g);
    n = 0;
    g = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_scroll) bus.cmd_scroll = 1'b0;
      if (!bus.busy) break;
      n++;
      if (bus.a_gnt || bus.b_gnt) g++;
      if (n == inject_at) bus.cmd_scroll = 1'b1;
    end
    bus.cmd_scroll = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.a_req      = 1'b0;
    bus.b_req      = 1'b0;
    bus.cmd_clear  = 1'b0;
    bus.cmd_scroll = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd0, 5'd1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 5'd1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 5'd0, 5'd1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'd0, 5'd1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd0, 5'd1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 5'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 5'd2, 5'd1, 8'h43, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 5'd3, 5'd1, 8'h44, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 5'd0, 5'd1, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 5'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    idle_inputs();
    bus.b_addr   = 5'd0;
    bus.b_data   = 8'h00;
    bus.lcd_addr = 5'd5;
    bus.a_req    = 1'b1;
    bus.a_addr   = 5'd5;
    bus.a_data   = 8'h41;

    // Reset and the automatic clear, with A requesting throughout.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd1);
    chk("reset a_gnt", {31'd0, bus.a_gnt}, 32'd0);
    chk("reset b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle(-1, n_busy, n_gnt);
    chk("init clear busy cycles", n_busy, 32);
    chk("init clear grants", n_gnt, 0);
    chk("first idle a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("first idle b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    chk("old value before commit", {24'd0, bus.lcd_data}, 32'h20);
    @(posedge clk); #1;
    bus.a_req = 1'b0;
    @(negedge clk);
    chk("write visible next cycle", {24'd0, bus.lcd_data}, 32'h41);
    chk("a_gnt dropped", {31'd0, bus.a_gnt}, 32'd0);
    fill_model(8'h20);
    model[5] = 8'h41;
    check_buf("after init");

    // Round-robin vectors.
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      bus.a_req      = vecs[v].a_req;
      bus.b_req      = vecs[v].b_req;
      bus.a_addr     = vecs[v].a_addr;
      bus.b_addr     = vecs[v].b_addr;
      bus.a_data     = vecs[v].a_data;
      bus.b_data     = vecs[v].b_data;
      bus.cmd_clear  = vecs[v].clr;
      bus.cmd_scroll = vecs[v].scr;
      @(negedge clk);
      chk($sformatf("vec%0d a_gnt", v), {31'd0, bus.a_gnt}, {31'd0, vecs[v].ea});
      chk($sformatf("vec%0d b_gnt", v), {31'd0, bus.b_gnt}, {31'd0, vecs[v].eb});
      chk($sformatf("vec%0d busy", v), {31'd0, bus.busy}, {31'd0, vecs[v].ebusy});
    end
    @(posedge clk); #1;
    idle_inputs();
    model[0] = 8'h41;
    model[1] = 8'h42;
    model[2] = 8'h43;
    model[3] = 8'h44;
    check_buf("after rr");

    // Load row 1 with 'a'..'p' and row 0 with 'X', then scroll.
    bus.a_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      bus.a_addr = (i < 16) ? 5'(16 + i) : 5'(i - 16);
      bus.a_data = (i < 16) ? 8'(8'h61 + i) : 8'h58;
    end
    @(posedge clk); #1;
    bus.a_req      = 1'b0;
    bus.cmd_scroll = 1'b1;
    @(posedge clk); #1;
    bus.cmd_scroll = 1'b0;
    wait_idle(-1, n_busy, n_gnt);
    chk("scroll busy cycles", n_busy, 32);
    for (int i = 0; i < 16; i++) begin
      model[i]      = 8'(8'h61 + i);
      model[i + 16] = 8'h20;
    end
    check_buf("after scroll");

    // Clear and scroll together with B waiting; scroll mid-clear is ignored.
    @(posedge clk); #1;
    bus.cmd_clear  = 1'b1;
    bus.cmd_scroll = 1'b1;
    bus.b_req      = 1'b1;
    bus.b_addr     = 5'd31;
    bus.b_data     = 8'h51;
    @(negedge clk);
    chk("cmd cycle b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    chk("cmd cycle busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.cmd_clear  = 1'b0;
    bus.cmd_scroll = 1'b0;
    wait_idle(10, n_busy, n_gnt);
    chk("clear+scroll busy cycles", n_busy, 32);
    chk("clear+scroll grants", n_gnt, 0);
    chk("b_gnt after clear", {31'd0, bus.b_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.b_req = 1'b0;
    fill_model(8'h20);
    model[31] = 8'h51;
    check_buf("after clear");

    // Reset at SCROLL_COPY cycle 8 for two cycles.
    @(posedge clk); #1;
    bus.cmd_scroll = 1'b1;
    @(posedge clk); #1;
    bus.cmd_scroll = 1'b0;
    bus.a_req      = 1'b1;
    bus.a_addr     = 5'd7;
    bus.a_data     = 8'h52;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-scroll rst busy", {31'd0, bus.busy}, 32'd1);
    chk("mid-scroll rst a_gnt", {31'd0, bus.a_gnt}, 32'd0);
    @(negedge clk);
    chk("rst held a_gnt", {31'd0, bus.a_gnt}, 32'd0);
    chk("rst held b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.a_req = 1'b0;
    rst       = 1'b0;
    wait_idle(-1, n_busy, n_gnt);
    chk("post-rst clear busy cycles", n_busy, 32);
    fill_model(8'h20);
    check_buf("after rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/lcd_text_arbiter.md
Name: lcd_text_arbiter

Overview:
- Owns the 32-byte character buffer that the LCD refresh controller scans: 2 rows x 16 characters.
  - Addresses 0-15 are the top row; addresses 16-31 are the bottom row.
- Serves the LCD's continuous combinational read port.
- Shares the single buffer write port between two requesters, A and B, using round-robin arbitration.
- Sequences the bulk buffer operations: clear, and scroll-up by one row.

Parameters:
- FILL_CHAR, 8'h20, character written by clear and by the scroll fill phase.
- ROW_LEN, 16, characters per row (fixed; buffer depth is 2*ROW_LEN = 32).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- lcd_addr  input  5  read address from the LCD controller.
- lcd_data  output  8  buffer[lcd_addr], combinational.
- a_req  input  1  requester A write request, level, held until granted.
- a_addr  input  5  requester A write address.
- a_data  input  8  requester A write data.
- a_gnt  output  1  requester A grant, combinational; the write commits at the edge ending the grant cycle.
- b_req, b_addr, b_data, b_gnt  same as A, for requester B.
- cmd_clear  input  1  single-cycle pulse: fill the whole buffer with FILL_CHAR.
- cmd_scroll  input  1  single-cycle pulse: copy row 1 to row 0, then fill row 1 with FILL_CHAR.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Storage: 32x8 register array. It is not reset directly; contents are initialised by the automatic clear after reset.
- Reset (async, while rst=1): state=CLEAR, idx=0, last=B.
  - Outputs during reset: busy=1, a_gnt=0, b_gnt=0.
  - On rst release the clear runs 32 cycles, then state goes to IDLE.
- States: CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL. idx is a 5-bit counter.
- CLEAR:
  - Each cycle mem[idx] <= FILL_CHAR and idx++.
  - At idx=31: idx<=0, state goes to IDLE.
- SCROLL_COPY:
  - idx runs 0..15; each cycle mem[idx] <= mem[idx+16].
  - At idx=15: idx<=16, state goes to SCROLL_FILL.
- SCROLL_FILL:
  - idx runs 16..31; each cycle mem[idx] <= FILL_CHAR.
  - At idx=31: idx<=0, state goes to IDLE.
- Operation durations: clear = 32 busy cycles; scroll = 32 busy cycles.
- IDLE priority, evaluated each cycle:
  1. cmd_clear: state goes to CLEAR, idx=0. No grant this cycle.
  2. Otherwise cmd_scroll: state goes to SCROLL_COPY, idx=0. No grant this cycle.
  3. Otherwise arbitration:
     - Only a_req: a_gnt=1.
     - Only b_req: b_gnt=1.
     - Both: grant the requester not equal to last.
     - On any grant: the chosen addr/data is written at the edge ending that cycle, and last <= the granted requester.
- If cmd_clear and cmd_scroll arrive together, clear wins and the scroll is dropped.
- Commands arriving while busy=1 are ignored (not queued).
- Requests while busy=1 get no grant. They must stay asserted and are served once IDLE.
- Grants:
  - At most one of a_gnt/b_gnt is high in any cycle.
  - A requester keeping req high after a grant is eligible again next cycle, subject to round-robin.
- lcd_data:
  - Purely combinational from the array.
  - A write to the address being read shows the old value until the committing edge, and the new value after it.
  - Bulk operations are visible progressively; no tearing protection is provided.
- Address width: 5 bits covers the full buffer. There are no out-of-range addresses.
  - The scroll source idx+16 is computed in 5 bits and never wraps (idx ≤ 15).
- rst asserted mid-CLEAR, mid-scroll, or during a grant:
  - An in-progress write is abandoned.
  - State goes to CLEAR, idx=0, last=B, and the full 32-cycle clear restarts after release.

Test Plan:
- Reset then release; hold a_req=1 throughout. Required: busy=1 for exactly 32 cycles, a_gnt=0 throughout, all 32 lcd_data reads = 8'h20, then busy=0 and a_gnt=1 on the first IDLE cycle.
- IDLE; a_req=1, a_addr=5, a_data=8'h41 for one cycle. Required: a_gnt=1 that cycle, lcd_addr=5 reads 8'h41 the next cycle, b_gnt=0.
- Both requesters held for 4 cycles (A addr 0 data 'A'; B addr 1 data 'B'). Required: grant order A,B,A,B, never both high, and mem[0]='A', mem[1]='B'.
- Load row1 with 'a'..'p' and row0 with 'X', then pulse cmd_scroll. Required: busy for 32 cycles; afterwards addr 0-15 = 'a'..'p' and addr 16-31 = 8'h20.
- Pulse cmd_clear and cmd_scroll in the same IDLE cycle, with b_req=1. Required: clear runs (32 cycles, all 8'h20), b_gnt=0 until busy falls, then b_gnt=1. Pulse cmd_scroll at busy cycle 10 of that clear: ignored, total busy still 32.
- Assert rst at cycle 8 of SCROLL_COPY for 2 cycles. Required: grants=0, busy=1 immediately; after release a full 32-cycle clear leaves the buffer all 8'h20.
